// File: rtl/subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// FSM encodings and default operand width.
package subtractor_pkg;

  localparam int N_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fullSubtractor.sv
// One-bit full subtractor cell: d = a - b - bin.
// bout is the borrow out of this bit.
module fullSubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_sequencer.sv
// Bit-serial N-bit subtractor: one full-subtractor step per cycle.
// Result z/b/v is registered and updated only on completion.
module serial_sub_sequencer
  import subtractor_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         bIn,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] z,
  output logic         b,
  output logic         v
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     x_q, x_d;
  logic [N-1:0]     y_q, y_d;
  logic [N-1:0]     w_q, w_d;
  logic             br_q, br_d;
  logic [N-1:0]     z_q, z_d;
  logic             b_q, b_d;
  logic             v_q, v_d;

  logic fs_d;
  logic fs_bout;

  fullSubtractor u_fs (
    .a    (x_q[cnt_q]),
    .b    (y_q[cnt_q]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    br_d    = br_q;
    z_d     = z_q;
    b_d     = b_q;
    v_d     = v_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          x_d     = x;
          y_d     = y;
          br_d    = bIn;
          cnt_d   = '0;
        end
      end
      RUN: begin
        w_d[cnt_q] = fs_d;
        br_d       = fs_bout;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          z_d     = w_d;
          b_d     = fs_bout;
          v_d     = (w_d[N-1] ^ x_q[N-1])
                  & (y_q[N-1] ^ x_q[N-1]);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      br_q    <= 1'b0;
      z_q     <= '0;
      b_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      br_q    <= br_d;
      z_q     <= z_d;
      b_q     <= b_d;
      v_q     <= v_d;
    end
  end

  // Status comes straight from state flops: no path from start.
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign z    = z_q;
  assign b    = b_q;
  assign v    = v_q;

endmodule

// File: tb/tb_serial_sub_sequencer.sv
// Scoreboard bench for serial_sub_sequencer (N=8).
// Expected results queued at accept, checked on done.
module tb_serial_sub_sequencer;

  localparam int N = 8;

  typedef struct packed {
    logic [N-1:0] z;
    logic         b;
    logic         v;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         bIn;
  logic         busy;
  logic         done;
  logic [N-1:0] z;
  logic         b;
  logic         v;

  int   checks;
  int   errors;
  int   done_cnt;
  res_t q[$];

  serial_sub_sequencer #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .bIn   (bIn),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .b     (b),
    .v     (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [N-1:0] a,
                                 input logic [N-1:0] s,
                                 input logic bi);
    res_t r;
    logic [N:0] d;
    d   = {1'b0, a} - {1'b0, s} - {{N{1'b0}}, bi};
    r.z = d[N-1:0];
    r.b = d[N];
    r.v = (a[N-1] != s[N-1]) && (d[N-1] != a[N-1]);
    return r;
  endfunction

  // Monitor: compare each done pulse against the queue head.
  always @(negedge clk) begin
    res_t e;
    if (rst_n && busy && done) begin
      errors++;
      $display("FAIL busy_done_overlap: busy=%b done=%b required not both 1",
               busy, done);
    end
    if (rst_n && done) begin
      done_cnt++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: z=%h b=%b v=%b with no pending op",
                 z, b, v);
      end else begin
        e = q.pop_front();
        if ({z, b, v} !== {e.z, e.b, e.v}) begin
          errors++;
          $display("FAIL result: got z=%h b=%b v=%b required z=%h b=%b v=%b",
                   z, b, v, e.z, e.b, e.v);
        end
      end
    end
  end

  task automatic issue(input logic [N-1:0] a,
                       input logic [N-1:0] s,
                       input logic bi);
    @(negedge clk);
    start = 1'b1;
    x     = a;
    y     = s;
    bIn   = bi;
    q.push_back(model(a, s, bi));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: pending=%0d required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    x     = '0;
    y     = '0;
    bIn   = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, z, b, v} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b z=%h b=%b v=%b required all 0",
               busy, done, z, b, v);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_latency();
    int busy_n;
    int done_at;
    busy_n  = 0;
    done_at = 0;
    issue(8'h05, 8'h03, 1'b0);
    // issue() returns at the negedge right after the accepting edge.
    for (int i = 1; i <= 10; i++) begin
      if (busy) busy_n++;
      if (done && done_at == 0) done_at = i;
      if (i < 10) @(negedge clk);
    end
    checks++;
    if (busy_n != N) begin
      errors++;
      $display("FAIL busy_cycles: got %0d required %0d", busy_n, N);
    end
    checks++;
    if (done_at != N + 1) begin
      errors++;
      $display("FAIL done_latency: got sample %0d required %0d", done_at, N + 1);
    end
    drain("basic");
  endtask

  task automatic test_vectors();
    issue(8'h00, 8'h01, 1'b0);
    drain("vec0");
    issue(8'h05, 8'h03, 1'b1);
    drain("vec1");
    issue(8'h80, 8'h01, 1'b0);
    drain("vec2");
    issue(8'h7F, 8'hFF, 1'b0);
    drain("vec3");
    for (int i = 0; i < 6; i++) begin
      issue(8'($urandom), 8'($urandom), 1'($urandom));
      drain("rand");
    end
  endtask

  task automatic test_ignore_start();
    int d0;
    int busy_n;
    issue(8'h33, 8'h11, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    x     = 8'hAA;
    y     = 8'h55;
    bIn   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("ignore");
    d0     = done_cnt;
    busy_n = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy) busy_n++;
    end
    checks++;
    if (busy_n != 0 || done_cnt != d0) begin
      errors++;
      $display("FAIL ignore_start: busy_cycles=%0d extra_done=%0d required 0/0",
               busy_n, done_cnt - d0);
    end
  endtask

  task automatic test_reset_midrun();
    int d0;
    issue(8'hF0, 8'h0F, 1'b0);
    drain("pre_reset");
    issue(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    checks++;
    if ({busy, done, z, b, v} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b done=%b z=%h b=%b v=%b required all 0",
               busy, done, z, b, v);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL aborted_done: got %0d pulses required 0", done_cnt - d0);
    end
    issue(8'h9C, 8'h3D, 1'b1);
    drain("post_reset");
  endtask

  task automatic test_back_to_back();
    int d0;
    logic [N-1:0] a;
    logic [N-1:0] s;
    logic         bi;
    d0 = done_cnt;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      a     = 8'($urandom);
      s     = 8'($urandom);
      bi    = 1'($urandom);
      start = 1'b1;
      x     = a;
      y     = s;
      bIn   = bi;
      if (i % (N + 2) == 0) q.push_back(model(a, s, bi));
    end
    @(negedge clk);
    start = 1'b0;
    drain("b2b");
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d done pulses required 3", done_cnt - d0);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    test_reset();
    test_basic_latency();
    test_vectors();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_sub_sequencer.md
SERIAL_SUB_SEQUENCER -- requirements
Module: serial_sub_sequencer

Interface
REQ-001 Parameter N, default 8: operand width in bits, N >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin one subtraction; sampled only in IDLE.
REQ-005 x  input  N  minuend; captured on the accepting edge.
REQ-006 y  input  N  subtrahend; captured on the accepting edge.
REQ-007 bIn  input  1  borrow-in; captured on the accepting edge.
REQ-008 busy  output  1  high while state is RUN.
REQ-009 done  output  1  one-cycle pulse, high while state is DONE.
REQ-010 z  output  N  registered difference x - y - bIn (mod 2^N).
REQ-011 b  output  1  registered borrow-out of the MSB stage.
REQ-012 v  output  1  registered signed-overflow flag.

Function
REQ-013 FSM states: IDLE, RUN, DONE. Transitions: IDLE->RUN on start=1; RUN->DONE on the edge processing bit N-1; DONE->IDLE unconditionally on the next edge.
REQ-014 Accepting edge (IDLE, start=1): load x, y into internal operand registers, load bIn into the borrow register, clear bit counter to 0.
REQ-015 Each RUN edge: compute one bit via a single 1-bit full-subtractor stage on operand bit [cnt], borrow register; write difference bit into work register bit [cnt]; borrow register <= stage borrow-out; cnt <= cnt+1.
REQ-016 Counter width ceil(log2 N); no wrap occurs, because RUN exits at cnt = N-1.
REQ-017 On the RUN->DONE edge: z <= completed work word; b <= final borrow-out; v <= (z[N-1] xor x[N-1]) and (y[N-1] xor x[N-1]), using the new z MSB and the captured x, y.
REQ-018 z, b, v SHALL change only on the RUN->DONE edge; they hold the previous result through IDLE and RUN.
REQ-019 Latency: done is high in the cycle beginning N edges after the accepting edge; next start is accepted no earlier than N+2 edges after the previous accepting edge.
REQ-020 start while RUN or DONE is ignored; it is not queued; input changes on x/y/bIn outside the accepting edge have no effect.
REQ-021 start held high continuously yields back-to-back operations, each re-sampling x/y/bIn on its own accepting edge.
REQ-022 busy and done SHALL never be high simultaneously.

Reset
REQ-023 rst_n low asynchronously forces: state=IDLE, cnt=0, operand/work/borrow registers=0, z=0, b=0, v=0, busy=0, done=0.
REQ-024 Reset mid-RUN aborts the operation; no done pulse is produced; z/b/v read 0.
REQ-025 After rst_n deasserts, the first rising edge with start=1 is an accepting edge.

Structure
REQ-026 Shared package subtractor_pkg holds FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default width constant.
REQ-027 The single 1-bit stage SHALL reuse the team's existing fullSubtractor cell; no other sub-module.
REQ-028 Target size 120-400 RTL lines; no combinational path from start to busy/done.

Verification (N=8)
REQ-029 x=0x05, y=0x03, bIn=0 -> z=0x02, b=0, v=0; done high exactly 8 edges after accept, busy high for 8 cycles.
REQ-030 x=0x00, y=0x01, bIn=0 -> z=0xFF, b=1, v=0; x=0x05, y=0x03, bIn=1 -> z=0x01, b=0, v=0.
REQ-031 x=0x80, y=0x01 -> z=0x7F, b=0, v=1; x=0x7F, y=0xFF -> z=0x80, b=1, v=1.
REQ-032 start pulsed with new operands at RUN cycle 3 -> ignored; result matches first operands; no second busy period.
REQ-033 rst_n low at RUN cycle 4 -> all outputs 0 immediately (before next edge); no done; fresh start after release completes normally.
REQ-034 start held high for 30 cycles with changing operands -> done pulses every 10 cycles, each result matching its own accepting-edge operands.
